// File: rtl/switch_debounce_ctrl.sv
// Switch synchroniser, per-bit debouncer, edge pulses and change-event latch.
// Optional change_count output when SW_CHANGE_COUNT_EN is defined.
module switch_debounce_ctrl #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_rise_mask,
  output logic [WIDTH-1:0] evt_fall_mask,
  output logic             evt_overrun,
  input  logic             evt_ack
`ifdef SW_CHANGE_COUNT_EN
  ,
  output logic [15:0]      change_count
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rm_q, rm_d;
  logic [WIDTH-1:0] fm_q, fm_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Any sample matching the stable level restarts that bit's count.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) flip[i] = 1'b1;
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign stable_d = stable_q ^ flip;
  assign rise_d   = flip & ~stable_q;
  assign fall_d   = flip & stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rm_d    = rm_q;
    fm_d    = fm_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (|flip) begin
          state_d = PEND;
          data_d  = stable_d;
          rm_d    = rise_d;
          fm_d    = fall_d;
          ovr_d   = 1'b0;
        end
      end
      PEND: begin
        if (|flip) begin
          data_d = stable_d;
          if (evt_ack) begin
            rm_d  = rise_d;
            fm_d  = fall_d;
            ovr_d = 1'b0;
          end else begin
            rm_d  = rm_q | rise_d;
            fm_d  = fm_q | fall_d;
            ovr_d = 1'b1;
          end
        end else if (evt_ack) begin
          state_d = IDLE;
          data_d  = '0;
          rm_d    = '0;
          fm_d    = '0;
          ovr_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rm_q    <= '0;
      fm_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rm_q    <= rm_d;
      fm_q    <= fm_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SW_CHANGE_COUNT_EN
  logic [15:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if ((|flip) && (ccnt_q != 16'hFFFF)) ccnt_d = ccnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) ccnt_q <= '0;
    else       ccnt_q <= ccnt_d;
  end

  assign change_count = ccnt_q;
`endif

  assign sw_stable     = stable_q;
  assign sw_rise       = rise_q;
  assign sw_fall       = fall_q;
  assign evt_valid     = (state_q == PEND);
  assign evt_data      = data_q;
  assign evt_rise_mask = rm_q;
  assign evt_fall_mask = fm_q;
  assign evt_overrun   = ovr_q;

endmodule
